// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//
// Decode-to-execute pipeline register of the RV32I core, directly upstream of
// the ALU. One decoded instruction is accepted per cycle. Both source operands
// are resolved against the EX/MEM and MEM/WB forward sources. The ALU a/b
// operands, the forwarded store data and the control bits are then captured
// into a single-entry slot.
//
// Handshake (both sides): a transfer happens on a rising edge where
// valid & ready are both high. A producer holds its payload stable while
// valid is high and ready is low. in_ready is a pure function of the slot
// state and the incoming operand indices; it never looks at in_valid.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   flush                   synchronous kill of the slot (highest priority)
//   in_valid / in_ready     upstream handshake
//   pc, imm                 instruction PC and sign-extended immediate
//   rs1_addr/rs2_addr/rd_addr  register indices
//   rs1_data/rs2_data       register-file read data
//   rs1_used/rs2_used       instruction actually reads the operand
//   a_sel, b_sel            0: rs1/rs2, 1: pc/imm
//   alu_sel                 ALU operation code, passed through untouched
//   reg_we/is_load/is_store instruction class and writeback control
//   exmem_*, memwb_*        forward sources (EX/MEM has priority)
//   out_valid / out_ready   downstream handshake
//   alu_a, alu_b, alu_sel_q, store_data, pc_q, rd_q,
//   reg_we_q, is_load_q, is_store_q   registered slot contents
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  input  logic [4:0]      rd_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            rs1_used,
  input  logic            rs2_used,
  input  logic            a_sel,
  input  logic            b_sel,
  input  logic [3:0]      alu_sel,
  input  logic            reg_we,
  input  logic            is_load,
  input  logic            is_store,
  input  logic            exmem_we,
  input  logic [4:0]      exmem_rd,
  input  logic [XLEN-1:0] exmem_data,
  input  logic            memwb_we,
  input  logic [4:0]      memwb_rd,
  input  logic [XLEN-1:0] memwb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_sel_q,
  output logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] pc_q,
  output logic [4:0]      rd_q,
  output logic            reg_we_q,
  output logic            is_load_q,
  output logic            is_store_q
);

  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;
  logic [XLEN-1:0] next_a;
  logic [XLEN-1:0] next_b;
  logic            hazard;
  logic            accept;
  logic            drain;

  // x0 is hard-wired to zero, so a forward source that targets x0 must never
  // leak through; EX/MEM holds the younger result and therefore wins.
  function automatic logic [XLEN-1:0] resolve(
    input logic [4:0]      addr,
    input logic [XLEN-1:0] rf_data,
    input logic            em_we,
    input logic [4:0]      em_rd,
    input logic [XLEN-1:0] em_data,
    input logic            mw_we,
    input logic [4:0]      mw_rd,
    input logic [XLEN-1:0] mw_data
  );
    logic [XLEN-1:0] r;
    if (addr == 5'd0)                  r = '0;
    else if (em_we && em_rd == addr)   r = em_data;
    else if (mw_we && mw_rd == addr)   r = mw_data;
    else                               r = rf_data;
    return r;
  endfunction

  always_comb begin
    fwd_rs1 = resolve(rs1_addr, rs1_data, exmem_we, exmem_rd, exmem_data,
                      memwb_we, memwb_rd, memwb_data);
    fwd_rs2 = resolve(rs2_addr, rs2_data, exmem_we, exmem_rd, exmem_data,
                      memwb_we, memwb_rd, memwb_data);
    next_a  = a_sel ? pc  : fwd_rs1;
    next_b  = b_sel ? imm : fwd_rs2;
  end

  // Load-use interlock: the load in the slot has no data yet, so a consumer
  // must wait one cycle until the load reaches a forward source. A load to
  // x0 produces nothing and never blocks.
  always_comb begin
    hazard = out_valid && is_load_q && (rd_q != 5'd0) &&
             ((rs1_used && rs1_addr == rd_q) ||
              (rs2_used && rs2_addr == rd_q));
  end

  assign in_ready = (!out_valid || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel_q  <= 4'b0000;
      store_data <= '0;
      pc_q       <= '0;
      rd_q       <= 5'd0;
      reg_we_q   <= 1'b0;
      is_load_q  <= 1'b0;
      is_store_q <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      alu_a      <= next_a;
      alu_b      <= next_b;
      alu_sel_q  <= alu_sel;
      store_data <= fwd_rs2;
      pc_q       <= pc;
      rd_q       <= rd_addr;
      reg_we_q   <= reg_we;
      is_load_q  <= is_load;
      is_store_q <= is_store;
    end else if (drain) begin
      // Payload is left stale; out_valid alone marks the bubble.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  localparam int PW = 140;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic        u1;
    logic        u2;
    logic        as;
    logic        bs;
    logic [3:0]  sel;
    logic        we;
    logic        ld;
    logic        st;
  } in_t;

  logic        clk, rst_n, flush, in_valid, in_ready;
  logic [31:0] pc, imm, rs1_data, rs2_data;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic        rs1_used, rs2_used, a_sel, b_sel;
  logic [3:0]  alu_sel;
  logic        reg_we, is_load, is_store;
  logic        exmem_we, memwb_we;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_data, memwb_data;
  logic        out_valid, out_ready;
  logic [31:0] alu_a, alu_b, store_data, pc_q;
  logic [3:0]  alu_sel_q;
  logic [4:0]  rd_q;
  logic        reg_we_q, is_load_q, is_store_q;

  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] dut_vec;
  int checks = 0;
  int errors = 0;

  assign dut_vec = {alu_a, alu_b, store_data, pc_q, alu_sel_q, rd_q,
                    reg_we_q, is_load_q, is_store_q};

  id_ex_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .pc(pc), .imm(imm),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_used(rs1_used), .rs2_used(rs2_used),
    .a_sel(a_sel), .b_sel(b_sel), .alu_sel(alu_sel),
    .reg_we(reg_we), .is_load(is_load), .is_store(is_store),
    .exmem_we(exmem_we), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
    .memwb_we(memwb_we), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel_q(alu_sel_q),
    .store_data(store_data), .pc_q(pc_q), .rd_q(rd_q),
    .reg_we_q(reg_we_q), .is_load_q(is_load_q), .is_store_q(is_store_q)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [PW-1:0] mk_exp(
    input logic [31:0] a, input logic [31:0] b, input logic [31:0] sd,
    input logic [31:0] p, input logic [3:0] sel, input logic [4:0] rd,
    input logic we, input logic ld, input logic st);
    return {a, b, sd, p, sel, rd, we, ld, st};
  endfunction

  function automatic in_t mk_in(
    input logic [31:0] p, input logic [31:0] im,
    input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
    input logic [31:0] d1, input logic [31:0] d2,
    input logic u1, input logic u2, input logic as, input logic bs,
    input logic [3:0] sel, input logic we, input logic ld, input logic st);
    in_t t;
    t.pc = p; t.imm = im; t.rs1 = r1; t.rs2 = r2; t.rd = rd;
    t.rs1d = d1; t.rs2d = d2; t.u1 = u1; t.u2 = u2; t.as = as; t.bs = bs;
    t.sel = sel; t.we = we; t.ld = ld; t.st = st;
    return t;
  endfunction

  task automatic check(input string name, input logic [PW-1:0] act,
                       input logic [PW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic set_fwd(input logic ew, input logic [4:0] er, input logic [31:0] ed,
                         input logic mw, input logic [4:0] mr, input logic [31:0] md);
    exmem_we = ew; exmem_rd = er; exmem_data = ed;
    memwb_we = mw; memwb_rd = mr; memwb_data = md;
  endtask

  // ---------------- driver ----------------
  task automatic send(input in_t t, input logic [PW-1:0] e, input bit drop,
                      output int stalls, output logic ov_acc);
    bit done;
    stalls = 0; done = 0; ov_acc = 1'b0;
    pc = t.pc; imm = t.imm; rs1_addr = t.rs1; rs2_addr = t.rs2; rd_addr = t.rd;
    rs1_data = t.rs1d; rs2_data = t.rs2d; rs1_used = t.u1; rs2_used = t.u2;
    a_sel = t.as; b_sel = t.bs; alu_sel = t.sel;
    reg_we = t.we; is_load = t.ld; is_store = t.st;
    in_valid = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (in_ready) begin
        ov_acc = out_valid;
        if (!drop) exp_q.push_back(e);
        done = 1;
      end else begin
        stalls++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_timeout actual=no_accept required=accept");
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output actual=%h required=none", dut_vec);
      end else begin
        check("slot_payload", dut_vec, exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  in_t t;
  int st;
  logic ova;

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    t = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0, 0, 0, 0);
    pc = 0; imm = 0; rs1_addr = 0; rs2_addr = 0; rd_addr = 0;
    rs1_data = 0; rs2_data = 0; rs1_used = 0; rs2_used = 0;
    a_sel = 0; b_sel = 0; alu_sel = 0; reg_we = 0; is_load = 0; is_store = 0;
    set_fwd(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_out_valid", PW'(out_valid), PW'(1'b0));
    check("reset_payload", dut_vec, '0);
    check("reset_in_ready", PW'(in_ready), PW'(1'b1));
    @(posedge clk); #1;

    // add x3,x1,x2
    t = mk_in(32'h40, 0, 1, 2, 3, 5, 7, 1, 1, 0, 0, 4'b0000, 1, 0, 0);
    send(t, mk_exp(5, 7, 7, 32'h40, 4'b0000, 3, 1, 0, 0), 0, st, ova);

    // forward priority: EX/MEM beats MEM/WB
    set_fwd(1, 4, 32'hAAAA0000, 1, 4, 32'h1111);
    t = mk_in(32'h44, 0, 4, 2, 7, 32'h9999, 7, 1, 1, 0, 0, 4'b0100, 1, 0, 0);
    send(t, mk_exp(32'hAAAA0000, 7, 7, 32'h44, 4'b0100, 7, 1, 0, 0), 0, st, ova);
    // EX/MEM disabled: MEM/WB wins
    set_fwd(0, 4, 32'hAAAA0000, 1, 4, 32'h1111);
    t = mk_in(32'h48, 0, 4, 2, 8, 32'h9999, 7, 1, 1, 0, 0, 4'b1000, 1, 0, 0);
    send(t, mk_exp(32'h1111, 7, 7, 32'h48, 4'b1000, 8, 1, 0, 0), 0, st, ova);
    // x0 ignores every source
    set_fwd(1, 0, 32'hDEAD, 1, 0, 32'hBEEF);
    t = mk_in(32'h4C, 0, 0, 0, 9, 32'h1234, 32'h5678, 1, 1, 0, 0, 4'b0110, 1, 0, 0);
    send(t, mk_exp(0, 0, 0, 32'h4C, 4'b0110, 9, 1, 0, 0), 0, st, ova);

    // pc/imm select, store data still forwarded rs2
    set_fwd(0, 0, 0, 1, 9, 32'h55);
    t = mk_in(32'h100, 32'hFFFFFFFC, 1, 9, 0, 32'h77, 3, 1, 1, 1, 1, 4'b0000, 0, 0, 1);
    send(t, mk_exp(32'h100, 32'hFFFFFFFC, 32'h55, 32'h100, 4'b0000, 0, 0, 0, 1), 0, st, ova);
    set_fwd(0, 0, 0, 0, 0, 0);

    // load-use: lw x5 then add x6,x5,x1
    t = mk_in(32'h200, 4, 1, 0, 5, 32'h1000, 0, 1, 0, 0, 1, 4'b0000, 1, 1, 0);
    send(t, mk_exp(32'h1000, 4, 0, 32'h200, 4'b0000, 5, 1, 1, 0), 0, st, ova);
    set_fwd(1, 5, 32'h77, 0, 0, 0);
    t = mk_in(32'h204, 0, 5, 1, 6, 0, 32'h1000, 1, 1, 0, 0, 4'b0000, 1, 0, 0);
    send(t, mk_exp(32'h77, 32'h1000, 32'h1000, 32'h204, 4'b0000, 6, 1, 0, 0), 0, st, ova);
    check("loaduse_stalls", PW'(st), PW'(1));
    check("loaduse_bubble", PW'(ova), PW'(1'b0));
    set_fwd(0, 0, 0, 0, 0, 0);

    // lw x0 never blocks a reader of x0
    t = mk_in(32'h300, 0, 1, 0, 0, 32'h10, 0, 1, 0, 0, 1, 4'b0000, 1, 1, 0);
    send(t, mk_exp(32'h10, 0, 0, 32'h300, 4'b0000, 0, 1, 1, 0), 0, st, ova);
    t = mk_in(32'h304, 0, 0, 0, 2, 32'hFF, 0, 1, 1, 0, 0, 4'b0111, 1, 0, 0);
    send(t, mk_exp(0, 0, 0, 32'h304, 4'b0111, 2, 1, 0, 0), 0, st, ova);
    check("x0_load_no_stall", PW'(st), PW'(0));

    // unused operand matching the load's rd does not stall (lui-style)
    t = mk_in(32'h308, 0, 1, 0, 5, 32'h20, 0, 1, 0, 0, 1, 4'b0000, 1, 1, 0);
    send(t, mk_exp(32'h20, 0, 0, 32'h308, 4'b0000, 5, 1, 1, 0), 0, st, ova);
    t = mk_in(32'h30C, 32'h12345000, 5, 0, 10, 0, 0, 0, 0, 1, 1, 4'b1111, 1, 0, 0);
    send(t, mk_exp(32'h30C, 32'h12345000, 0, 32'h30C, 4'b1111, 10, 1, 0, 0), 0, st, ova);
    check("unused_rs_no_stall", PW'(st), PW'(0));

    // backpressure: hold 3 cycles, then back-to-back
    t = mk_in(32'h400, 0, 1, 2, 11, 32'hA, 32'hB, 1, 1, 0, 0, 4'b0001, 1, 0, 0);
    send(t, mk_exp(32'hA, 32'hB, 32'hB, 32'h400, 4'b0001, 11, 1, 0, 0), 0, st, ova);
    out_ready = 1'b0;
    fork
      begin
        t = mk_in(32'h404, 0, 1, 2, 12, 32'hC, 32'hD, 1, 1, 0, 0, 4'b0101, 1, 0, 0);
        send(t, mk_exp(32'hC, 32'hD, 32'hD, 32'h404, 4'b0101, 12, 1, 0, 0), 0, st, ova);
      end
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("stall_in_ready", PW'(in_ready), PW'(1'b0));
          check("stall_hold", dut_vec,
                mk_exp(32'hA, 32'hB, 32'hB, 32'h400, 4'b0001, 11, 1, 0, 0));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    check("backpressure_stalls", PW'(st), PW'(3));
    t = mk_in(32'h408, 0, 1, 2, 13, 32'hE, 32'hF, 1, 1, 0, 0, 4'b1101, 1, 0, 0);
    send(t, mk_exp(32'hE, 32'hF, 32'hF, 32'h408, 4'b1101, 13, 1, 0, 0), 0, st, ova);

    // flush wins over an accept: input dropped
    flush = 1'b1;
    t = mk_in(32'h500, 0, 1, 2, 14, 1, 2, 1, 1, 0, 0, 4'b0010, 1, 0, 0);
    send(t, '0, 1, st, ova);
    flush = 1'b0;
    @(negedge clk);
    check("flush_out_valid", PW'(out_valid), PW'(1'b0));
    @(posedge clk); #1;

    // flush while stalled
    out_ready = 1'b0;
    t = mk_in(32'h600, 0, 1, 2, 15, 3, 4, 1, 1, 0, 0, 4'b0011, 1, 0, 0);
    send(t, mk_exp(3, 4, 4, 32'h600, 4'b0011, 15, 1, 0, 0), 0, st, ova);
    @(negedge clk);
    check("stalled_in_ready_no_valid", PW'(in_ready), PW'(1'b0));
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("flush_stalled_out_valid", PW'(out_valid), PW'(1'b0));
    exp_q.delete();
    @(posedge clk); #1;

    // asynchronous reset mid-stall
    t = mk_in(32'h700, 0, 1, 2, 16, 32'h5A, 32'hA5, 1, 1, 0, 0, 4'b0100, 1, 0, 1);
    send(t, mk_exp(32'h5A, 32'hA5, 32'hA5, 32'h700, 4'b0100, 16, 1, 0, 1), 0, st, ova);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check("async_reset_out_valid", PW'(out_valid), PW'(1'b0));
    check("async_reset_payload", dut_vec, '0);
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;

    // recovery
    t = mk_in(32'h800, 0, 1, 2, 17, 32'h21, 32'h12, 1, 1, 0, 0, 4'b0000, 1, 0, 0);
    send(t, mk_exp(32'h21, 32'h12, 32'h12, 32'h800, 4'b0000, 17, 1, 0, 0), 0, st, ova);

    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(posedge clk);
    @(posedge clk);
    check("queue_drained", PW'(exp_q.size()), PW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
